ex_muldiv_unit: RTL and testbench
=================================

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request an operation; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 srcA  input  32  multiplicand/dividend, from the EX-stage operand A (forwarded) path.
REQ-007 srcB  input  32  multiplier/divisor, from the EX-stage operand B (forwarded) path.
REQ-008 flush  input  1  abort any operation in flight.
REQ-009 busy  output  1  high while an accepted operation is unfinished; used to stall IF/ID and ID/EX.
REQ-010 done  output  1  registered one-cycle pulse marking a completed result.
REQ-011 hi  output  32  HI register: product upper half or remainder.
REQ-012 lo  output  32  LO register: product lower half or quotient.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and FIX.
REQ-014 In IDLE, with start=1 and flush=0 at edge E0: latch op, latch operand magnitudes (signed ops) or raw values (unsigned ops), latch both sign bits, set count=31, go to RUN.
REQ-015 RUN SHALL perform one radix-2 iteration per edge: shift-add for multiply, restoring shift-subtract for divide, on a 64-bit working register. Count decrements each edge; at count=0 the next state is FIX (32 iterations, edges E1..E32).
REQ-016 FIX (edge E33) SHALL apply sign correction, write hi/lo, set done=1 for one cycle, and return to IDLE.
REQ-017 Result latency SHALL be exactly 33 rising edges from the start edge to hi/lo/done valid.
REQ-018 Signed multiply: negate the 64-bit product iff the operand signs differ.
REQ-019 Signed divide: negate the quotient iff the signs differ; the remainder takes the dividend's sign.
REQ-020 0x80000000 / 0xFFFFFFFF (DIV) SHALL give lo=0x80000000, hi=0x00000000, with no exception.
REQ-021 Divisor zero (DIV or DIVU) SHALL give hi=srcA as latched, lo=0xFFFFFFFF, at normal latency.
REQ-022 busy SHALL be 1 in RUN and FIX and 0 in IDLE. It is registered, so it is high from the cycle after E0 through the cycle before done.
REQ-023 start while busy=1 SHALL be ignored, with no queueing.
REQ-024 start during the done cycle SHALL be accepted, giving back-to-back operations.
REQ-025 flush=1 at any edge SHALL force IDLE and clear count. hi/lo SHALL stay unchanged and no done SHALL be produced.
REQ-026 flush and start in the same IDLE cycle: flush wins, and nothing is accepted.
REQ-027 hi/lo SHALL change only at the FIX edge or at reset.
REQ-028 op/srcA/srcB SHALL be ignored outside the start edge; later changes do not affect the result.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, count=0, busy=0, done=0, hi=0, lo=0, and clear the working register.
REQ-030 Reset mid-operation SHALL discard the operation; the first start after release begins a fresh operation.
REQ-031 Release of rst_n is assumed synchronous to clk from the system reset synchroniser; no internal synchroniser is required.

Structure
REQ-032 A shared package muldiv_pkg SHALL hold the op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), the state enum, and the constant MD_ITER=32.
REQ-033 One combinational sub-module, muldiv_step, SHALL compute a single multiply-or-divide iteration; the FSM, counter, sign logic and hi/lo live in ex_muldiv_unit.
REQ-034 Single clock domain, no latches, no multi-cycle paths.

Verification
REQ-035 MULT srcA=0xFFFFFFFD (-3), srcB=5 -> done at edge E0+33; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for 33 cycles.
REQ-036 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-037 DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 DIVU 100 / 0 -> hi=0x00000064, lo=0xFFFFFFFF, done at normal latency.
REQ-039 Load hi/lo with a known result. Start MULT, then assert flush at E0+10 -> busy=0 next cycle, no done, hi/lo unchanged. A start during the flush cycle is also ignored.
REQ-040 Start DIVU, assert rst_n=0 at E0+20 -> all outputs 0 immediately. Two back-to-back ops, the second started on the first's done cycle -> second done exactly 33 edges later.

Source files
------------

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared op encodings, FSM state type and iteration count for the
//            EX-stage multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Purpose  : One radix-2 iteration: shift-add multiply or restoring divide on
//            a 64-bit working register {upper, lower}.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic        is_div,
    input  logic [63:0] work,
    input  logic [31:0] operand,
    output logic [63:0] work_next
);

    logic [32:0] w_sum;
    logic [32:0] w_rem;
    logic [31:0] w_diff;
    logic        w_fits;

    always_comb begin
        w_sum     = {1'b0, work[63:32]} + {1'b0, (work[0] ? operand : 32'd0)};
        // Partial remainder after shifting in the next dividend bit
        w_rem     = work[63:31];
        w_fits    = (w_rem >= {1'b0, operand});
        w_diff    = w_rem[31:0] - operand;
        work_next = {w_sum, work[31:1]};
        if (is_div) begin
            if (w_fits) begin
                work_next = {w_diff, work[30:0], 1'b1};
            end else begin
                work_next = {work[62:0], 1'b0};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Purpose  : Iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO result registers,
//            fixed 33-edge latency, flush and async active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [4:0] C_COUNT_INIT = 5'(MD_ITER - 1);

    md_state_e          r_state;
    md_state_e          w_state_next;
    logic [4:0]         r_count;
    logic [1:0]         r_op;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [WIDTH-1:0]   r_divisor;
    logic [2*WIDTH-1:0] r_work;

    logic [2*WIDTH-1:0] w_work_next;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic               w_signed;
    logic               w_neg_res;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_hi_fix;
    logic [WIDTH-1:0]   w_lo_fix;
    logic               w_busy_next;
    logic               w_done_next;

    muldiv_step u_step (
        .is_div    (r_op[1]),
        .work      (r_work),
        .operand   (r_divisor),
        .work_next (w_work_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)          w_state_next = ST_RUN;
            ST_RUN:  if (r_count == '0)  w_state_next = ST_FIX;
            ST_FIX:                      w_state_next = ST_IDLE;
            default:                     w_state_next = ST_IDLE;
        endcase
        if (flush) begin
            w_state_next = ST_IDLE;
        end
        w_busy_next = (w_state_next != ST_IDLE);
        w_done_next = (r_state == ST_FIX) && !flush;
    end

    // Signed ops iterate on magnitudes; the sign is restored in FIX
    always_comb begin
        w_mag_a   = (!op[0] && srcA[WIDTH-1]) ? -srcA : srcA;
        w_mag_b   = (!op[0] && srcB[WIDTH-1]) ? -srcB : srcB;
        w_signed  = !r_op[0];
        w_neg_res = w_signed && (r_sign_a ^ r_sign_b);
        w_prod    = w_neg_res ? -r_work : r_work;
        w_quot    = w_neg_res ? -r_work[WIDTH-1:0] : r_work[WIDTH-1:0];
        w_rem     = (w_signed && r_sign_a) ? -r_work[2*WIDTH-1:WIDTH]
                                           : r_work[2*WIDTH-1:WIDTH];
        w_hi_fix  = w_prod[2*WIDTH-1:WIDTH];
        w_lo_fix  = w_prod[WIDTH-1:0];
        if (r_op[1]) begin
            w_hi_fix = w_rem;
            w_lo_fix = (r_divisor == '0) ? '1 : w_quot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_op      <= MD_MULT;
            r_sign_a  <= 1'b0;
            r_sign_b  <= 1'b0;
            r_divisor <= '0;
            r_work    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            busy <= w_busy_next;
            done <= w_done_next;
            if (flush) begin
                r_count <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_op      <= op;
                            r_sign_a  <= srcA[WIDTH-1];
                            r_sign_b  <= srcB[WIDTH-1];
                            r_divisor <= w_mag_b;
                            r_work    <= {{WIDTH{1'b0}}, w_mag_a};
                            r_count   <= C_COUNT_INIT;
                        end
                    end
                    ST_RUN: begin
                        r_work  <= w_work_next;
                        r_count <= r_count - 5'd1;
                    end
                    ST_FIX: begin
                        hi <= w_hi_fix;
                        lo <= w_lo_fix;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// Testbench for ex_muldiv_unit: transaction-level reference model with a
// per-cycle compare process, plus directed vectors with literal results.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int passes = 0;
    bit cmp_en = 1'b0;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .srcA  (srcA),
        .srcB  (srcB),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // Architectural result {hi, lo} from plain arithmetic
    function automatic logic [63:0] ref_result(input logic [1:0] f_op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa, sb, q, r;
        sa = $signed(a);
        sb = $signed(b);
        case (f_op)
            2'b00: return sa * sb;
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Model: idle when no edges remain; a result appears 33 edges after accept
    int          m_rem;
    logic        m_busy, m_done;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem = 0; m_busy = 0; m_done = 0; m_hi = 0; m_lo = 0;
        end else begin
            m_done = 0;
            if (flush) begin
                m_rem = 0; m_busy = 0;
            end else if (m_rem == 0) begin
                if (start) begin
                    m_res = ref_result(op, srcA, srcB);
                    m_rem = 33; m_busy = 1;
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    {m_hi, m_lo} = m_res;
                    m_done = 1; m_busy = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_busy", {63'd0, busy}, {63'd0, m_busy});
            chk("cyc_done", {63'd0, done}, {63'd0, m_done});
            chk("cyc_hi", {32'd0, hi}, {32'd0, m_hi});
            chk("cyc_lo", {32'd0, lo}, {32'd0, m_lo});
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
        int lat, bcyc;
        op = o; srcA = a; srcB = b; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        srcA = $urandom; srcB = $urandom; op = 2'($urandom);
        bcyc = busy ? 1 : 0;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (busy) bcyc++;
            if (done) begin
                lat = n;
                break;
            end
        end
        chk({name, "_latency"}, 64'(lat), 64'd33);
        chk({name, "_busy_cycles"}, 64'(bcyc), 64'd33);
        chk({name, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        chk({name, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    endtask

    initial begin
        int dcnt;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cmp_en = 1'b1;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);

        run_op(2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_neg3x5");
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg7by2");
        run_op(2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7byneg2");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf");
        run_op(2'b11, 32'd100, 32'd0, 32'h00000064, 32'hFFFFFFFF, "divu_by0");
        run_op(2'b10, 32'hFFFFFF9C, 32'd0, 32'hFFFFFF9C, 32'hFFFFFFFF, "div_neg_by0");
        run_op(2'b11, 32'd1000, 32'd7, 32'h00000006, 32'h0000008E, "divu_1000by7");

        // Flush mid-operation, with a start in the same cycle
        op = 2'b00; srcA = 32'd3; srcB = 32'd4; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (9) @(posedge clk);
        #2 flush = 1'b1; start = 1'b1;
        @(posedge clk); #2 flush = 1'b0; start = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_hi", {32'd0, hi}, 64'h6);
        chk("flush_lo", {32'd0, lo}, 64'h8E);
        dcnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        chk("flush_no_done", 64'(dcnt), 64'd0);

        // Flush and start together while idle
        #1 flush = 1'b1; start = 1'b1;
        @(posedge clk); #2 flush = 1'b0; start = 1'b0;
        chk("idle_flush_start_busy", {63'd0, busy}, 64'd0);
        repeat (3) @(posedge clk);

        // Reset in the middle of a DIVU
        #2 op = 2'b11; srcA = 32'd1000; srcB = 32'd3; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_hi", {32'd0, hi}, 64'd0);
        chk("midrst_lo", {32'd0, lo}, 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Back-to-back: second start lands in the first's done cycle
        run_op(2'b00, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, "b2b_first");
        run_op(2'b11, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF, "b2b_second");

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
